bus_initiator: RTL and testbench



---
 rtl/bus_initiator.sv | 115 +++++++++++
 tb/tb_bus_initiator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// Single-outstanding initiator for the shared memory-mapped peripheral bus.
// Core request -> bus strobes until slave ack or timeout -> core response.
module bus_initiator #(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              write_o,
  output logic              read_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg;
  logic       req_fire, rsp_fire, ack_hit, timeout_hit;

  assign req_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = (state_reg == RESP);
  assign busy_o      = (state_reg != IDLE);
  assign req_fire    = req_valid_i & req_ready_o;
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;

  // An undriven (X/Z) ack line fails the if-test and so never counts as an ack.
  always_comb begin
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    if (state_reg == ACCESS) begin
      if (ack_i) begin
        ack_hit = 1'b1;
      end else if (cnt_reg == CNT_LAST) begin
        timeout_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_fire) state_next = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes drop on the same edge that sees the ack, so a zero-wait slave
  // gets exactly one select cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      write_o     <= 1'b0;
      read_o      <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            addr_o  <= req_addr_i;
            data_o  <= req_write_i ? req_wdata_i : '0;
            write_o <= req_write_i;
            read_o  <= ~req_write_i;
            cnt_reg <= '0;
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            rsp_rdata_o <= read_o ? data_i : '0;
            rsp_err_o   <= 1'b0;
            write_o     <= 1'b0;
            read_o      <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            write_o     <= 1'b0;
            read_o      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: per-scenario tasks with a response
// scoreboard filled at request time and drained at response handshake.
module tb_bus_initiator;

  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        write_s, read_s;
  logic [31:0] addr_s, data_s;
  logic [31:0] data_in = 32'h0;
  logic        ack = 1'b0;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  rsp_t sb_q[$];

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT(TO), .DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .write_o(write_s), .read_o(read_s), .addr_o(addr_s), .data_o(data_s),
    .data_i(data_in), .ack_i(ack), .busy_o(busy)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, write_s, read_s, busy} !== 6'b100000 ||
        rsp_rdata !== 32'h0 || addr_s !== 32'h0 || data_s !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b rv=%b err=%b wr=%b rd=%b busy=%b rdata=%h addr=%h data=%h want 1 0 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, write_s, read_s, busy, rsp_rdata, addr_s, data_s);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b rv=%b want 1 0 0", req_ready, busy, rsp_valid);
    end
  endtask

  // One access: ack_at = strobe cycle the slave acks on (0 = never); stall = cycles
  // of rsp_ready low, during which a spurious ack is also driven.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_at, input logic [31:0] rd, input int stall,
                            input string name);
    int          n;
    int          exp_n;
    logic        ok_ack;
    rsp_t        exp;
    logic [31:0] held_rdata;
    logic        held_err;
    ok_ack    = (ack_at >= 1 && ack_at <= TO);
    exp_n     = ok_ack ? ack_at : TO;
    exp.rdata = (ok_ack && !wr) ? rd : 32'h0;
    exp.err   = !ok_ack;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    sb_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      checks++;
      if (write_s !== wr || read_s !== !wr || addr_s !== addr || data_s !== (wr ? wdata : 32'h0)) begin
        errors++;
        $display("FAIL %s strobe_cyc%0d: wr=%b rd=%b addr=%h data=%h want wr=%b rd=%b addr=%h data=%h",
                 name, n + 1, write_s, read_s, addr_s, data_s, wr, !wr, addr, wr ? wdata : 32'h0);
      end
      n++;
      ack     = (n == ack_at);
      data_in = (n == ack_at) ? rd : $urandom;
      @(negedge clk);
      ack = 1'b0;
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s strobe_cycles: got %0d want %0d", name, n, exp_n);
    end
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    rsp_ready  = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held_rdata || rsp_err !== held_err ||
          req_ready !== 1'b0 || read_s !== 1'b0 || write_s !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s resp_hold%0d: rv=%b rdata=%h err=%b rdy=%b rd=%b wr=%b busy=%b want 1 %h %b 0 0 0 1",
                 name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, read_s, write_s, busy, held_rdata, held_err);
      end
      if (i < stall) begin
        ack = 1'b1; data_in = $urandom;
        @(negedge clk);
        ack = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    exp = sb_q.pop_front();
    checks++;
    if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
      errors++;
      $display("FAIL %s response: rdata=%h err=%b want rdata=%h err=%b", name, rsp_rdata, rsp_err, exp.rdata, exp.err);
    end
    $display("txn %s wr=%b addr=%h rdata=%h err=%b strobes=%0d", name, wr, addr, rsp_rdata, rsp_err, n);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: rv=%b rdy=%b busy=%b want 0 1 0", name, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_read_zero_wait;
    run_access(1'b0, 32'h4000_0004, 32'h0, 1, 32'h0000_0123, 0, "read_timer");
  endtask

  task automatic test_write_wait;
    run_access(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D, 0, "write_wait3");
  endtask

  task automatic test_timeout;
    run_access(1'b0, 32'h5000_0000, 32'h0, 0, 32'h0, 0, "read_unmapped");
    run_access(1'b0, 32'h4000_0004, 32'h0, 2, 32'h0000_0456, 0, "read_after_timeout");
  endtask

  task automatic test_backpressure;
    run_access(1'b0, 32'h4000_0008, 32'h0, 1, 32'hA5A5_A5A5, 5, "read_backpressure");
  endtask

  task automatic test_timeout_boundary;
    run_access(1'b0, 32'h4000_0020, 32'h0, TO, 32'h0000_0077, 0, "ack_on_last_cycle");
    run_access(1'b0, 32'h4000_0024, 32'h0, TO + 1, 32'h0000_0088, 0, "ack_one_late");
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0004;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (read_s !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid precondition_read: got %b want 1", read_s);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (read_s !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async_clear: rd=%b rv=%b busy=%b want 0 0 0", read_s, rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; data_in = $urandom;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || read_s !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid no_stale%0d: rv=%b rdy=%b rd=%b want 0 1 0", i, rsp_valid, req_ready, read_s);
      end
    end
    ack = 1'b0;
    $display("txn reset_mid_access addr=40000004 discarded");
  endtask

  task automatic test_back_to_back;
    int   last_acc;
    int   accepted;
    int   got_cnt;
    rsp_t exp;
    rsp_t nxt;
    rsp_ready = 1'b1; req_write = 1'b0;
    last_acc = -1; accepted = 0; got_cnt = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 40 && got_cnt < 4; cyc++) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected_rsp: rdata=%h", rsp_rdata);
        end else begin
          exp = sb_q.pop_front();
          if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
            errors++;
            $display("FAIL b2b rsp%0d: rdata=%h err=%b want rdata=%h err=%b", got_cnt, rsp_rdata, rsp_err, exp.rdata, exp.err);
          end
          $display("txn b2b%0d rdata=%h err=%b", got_cnt, rsp_rdata, rsp_err);
        end
        got_cnt++;
      end
      ack       = read_s;
      data_in   = addr_s ^ 32'h5A5A_0F0F;
      req_valid = (accepted < 4);
      req_addr  = 32'h4000_0100 + 32'(accepted * 4);
      if (req_valid && req_ready === 1'b1) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL b2b interval: got %0d want 3", cyc - last_acc);
          end
        end
        last_acc  = cyc;
        nxt.rdata = req_addr ^ 32'h5A5A_0F0F;
        nxt.err   = 1'b0;
        sb_q.push_back(nxt);
        accepted++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; ack = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (got_cnt != 4) begin
      errors++;
      $display("FAIL b2b count: got %0d want 4", got_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_backpressure();
    test_timeout_boundary();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
